// File: rtl/mgt_01_i_writeback_arbiter_pkg.sv
// Shared types for the MicroGT-01 integer writeback stage: register names, data bus,
// holding-entry record and the round-robin pointer helper.
package mgt_01_i_writeback_arbiter_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned N_SRC = 3;

  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_MUL = 1;
  localparam int unsigned WB_SRC_LSU = 2;

  typedef logic [XLEN-1:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  typedef struct packed {
    logic        valid;
    i_register_e rd;
    data_bus_t   data;
  } wb_entry_t;

  // Pointer value after a grant: the source following the winner.
  function automatic logic [1:0] rr_next(input logic [N_SRC-1:0] gnt);
    logic [1:0] nxt;
    if (gnt[WB_SRC_ALU]) begin
      nxt = 2'd1;
    end else if (gnt[WB_SRC_MUL]) begin
      nxt = 2'd2;
    end else begin
      nxt = 2'd0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mgt_01_i_writeback_arbiter_if.sv
// Result-source handshake and register-file write port of the integer writeback stage.
interface mgt_01_i_writeback_arbiter_if;
  import mgt_01_i_writeback_arbiter_pkg::*;

  logic [N_SRC-1:0] src_valid_i;
  i_register_e      src_rd_i   [N_SRC];
  data_bus_t        src_data_i [N_SRC];
  logic [N_SRC-1:0] src_ready_o;
  logic             we_o;
  i_register_e      w_iaddr_o;
  data_bus_t        wr_idata_o;
  logic [31:0]      busy_mask_o;

  modport master (
    output src_valid_i, src_rd_i, src_data_i,
    input  src_ready_o, we_o, w_iaddr_o, wr_idata_o, busy_mask_o
  );

  modport slave (
    input  src_valid_i, src_rd_i, src_data_i,
    output src_ready_o, we_o, w_iaddr_o, wr_idata_o, busy_mask_o
  );

endinterface

// File: rtl/mgt_01_rr_arbiter_3.sv
// Three-way round-robin grant: one-hot winner among requests, searching from ptr_i.
module mgt_01_rr_arbiter_3
  import mgt_01_i_writeback_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_SRC-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (ptr_i)
      2'd1: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd2: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      // Pointer value 3 never occurs; treat it like 0.
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mgt_01_i_writeback_arbiter.sv
// Integer writeback stage: one holding entry per result source, round-robin onto the
// single register-file write port, plus the pending-write mask used for RAW stalls.
module mgt_01_i_writeback_arbiter
  import mgt_01_i_writeback_arbiter_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          stall_i,
  mgt_01_i_writeback_arbiter_if.slave   wb
);

  wb_entry_t        hold_q [N_SRC];
  logic [1:0]       rr_ptr_q;
  logic             we_q;
  i_register_e      w_iaddr_q;
  data_bus_t        wr_idata_q;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] arb_gnt;
  logic [N_SRC-1:0] gnt;
  logic [N_SRC-1:0] src_ready;
  logic [N_SRC-1:0] load;
  i_register_e      sel_rd;
  data_bus_t        sel_data;
  logic [31:0]      busy;

  always_comb begin
    req = '0;
    for (int s = 0; s < N_SRC; s++) begin
      req[s] = hold_q[s].valid;
    end
  end

  mgt_01_rr_arbiter_3 u_rr_arbiter (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  assign gnt = stall_i ? '0 : arb_gnt;

  // Ready depends only on state and grant so there is no valid-to-ready path.
  always_comb begin
    src_ready = '0;
    load      = '0;
    for (int s = 0; s < N_SRC; s++) begin
      src_ready[s] = !stall_i && (!hold_q[s].valid || gnt[s]);
      load[s]      = wb.src_valid_i[s] && src_ready[s] && (wb.src_rd_i[s] != X0);
    end
  end

  always_comb begin
    sel_rd   = X0;
    sel_data = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (gnt[s]) begin
        sel_rd   = hold_q[s].rd;
        sel_data = hold_q[s].data;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (hold_q[s].valid) busy[hold_q[s].rd] = 1'b1;
    end
    if (we_q) busy[w_iaddr_q] = 1'b1;
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < N_SRC; s++) begin
        hold_q[s] <= '{valid: 1'b0, rd: X0, data: '0};
      end
      rr_ptr_q   <= 2'd0;
      we_q       <= 1'b0;
      w_iaddr_q  <= X0;
      wr_idata_q <= '0;
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        if (load[s]) begin
          hold_q[s] <= '{valid: 1'b1, rd: wb.src_rd_i[s], data: wb.src_data_i[s]};
        end else if (gnt[s]) begin
          hold_q[s].valid <= 1'b0;
        end
      end
      we_q <= |gnt;
      if (|gnt) begin
        w_iaddr_q  <= sel_rd;
        wr_idata_q <= sel_data;
        rr_ptr_q   <= rr_next(gnt);
      end
    end
  end

  assign wb.src_ready_o = src_ready;
  assign wb.we_o        = we_q;
  assign wb.w_iaddr_o   = w_iaddr_q;
  assign wb.wr_idata_o  = wr_idata_q;
  assign wb.busy_mask_o = busy;

  // Producers must never launch a result whose destination is still pending here.
  for (genvar s = 0; s < N_SRC; s++) begin : g_order_chk
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (wb.src_valid_i[s] && src_ready[s] && (wb.src_rd_i[s] != X0)) |-> !busy[wb.src_rd_i[s]]);
  end

endmodule

// File: tb/tb_mgt_01_i_writeback_arbiter.sv
// Directed bench for the integer writeback arbiter: a cycle-by-cycle vector table followed
// by a hand-written mid-operation reset sequence.
module tb_mgt_01_i_writeback_arbiter;
  import mgt_01_i_writeback_arbiter_pkg::*;

  typedef struct packed {
    logic             stall;
    logic [2:0]       valid;
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] data;
    logic [2:0]       ready;
    logic             we;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      busy;
  } vec_t;

  localparam int NVEC = 26;

  logic clk;
  logic rst_n;
  logic stall;
  int   checks;
  int   failures;
  vec_t vecs [NVEC];

  mgt_01_i_writeback_arbiter_if wbif ();

  mgt_01_i_writeback_arbiter dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .stall_i (stall),
    .wb      (wbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic st, input logic [2:0] v,
                              input logic [4:0] r0, input logic [31:0] d0,
                              input logic [4:0] r1, input logic [31:0] d1,
                              input logic [4:0] r2, input logic [31:0] d2,
                              input logic [2:0] rdy, input logic we, input logic [4:0] a,
                              input logic [31:0] wd, input logic [31:0] bm);
    vec_t x;
    x.stall = st;   x.valid = v;
    x.rd[0] = r0;   x.data[0] = d0;
    x.rd[1] = r1;   x.data[1] = d1;
    x.rd[2] = r2;   x.data[2] = d2;
    x.ready = rdy;  x.we = we;  x.addr = a;  x.wdata = wd;  x.busy = bm;
    return x;
  endfunction

  function automatic vec_t idle(input logic [2:0] rdy, input logic we, input logic [4:0] a,
                                input logic [31:0] wd, input logic [31:0] bm);
    return mk(1'b0, 3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, rdy, we, a, wd, bm);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall;
    for (int s = 0; s < N_SRC; s++) begin
      wbif.src_valid_i[s] = v.valid[s];
      wbif.src_rd_i[s]    = i_register_e'(v.rd[s]);
      wbif.src_data_i[s]  = v.data[s];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;

    // Table rows: inputs for the cycle, and outputs expected in that same cycle.
    vecs[0]  = idle(3'b111, 1'b0, 5'd0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b0, 3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33,
                  3'b111, 1'b0, 5'd0, 32'h0, 32'h0);
    vecs[2]  = idle(3'b001, 1'b0, 5'd0, 32'h0, 32'h0000_000E);
    vecs[3]  = idle(3'b011, 1'b1, 5'd1, 32'h11, 32'h0000_000E);
    vecs[4]  = idle(3'b111, 1'b1, 5'd2, 32'h22, 32'h0000_000C);
    vecs[5]  = idle(3'b111, 1'b1, 5'd3, 32'h33, 32'h0000_0008);
    vecs[6]  = mk(1'b0, 3'b001, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd0, 32'h0,
                  3'b111, 1'b0, 5'd3, 32'h33, 32'h0);
    vecs[7]  = idle(3'b111, 1'b0, 5'd3, 32'h33, 32'h0000_0020);
    vecs[8]  = idle(3'b111, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0020);
    vecs[9]  = mk(1'b0, 3'b010, 5'd0, 32'h0, 5'd0, 32'h99, 5'd0, 32'h0,
                  3'b111, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    vecs[10] = idle(3'b111, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    vecs[11] = idle(3'b111, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    vecs[12] = mk(1'b0, 3'b001, 5'd6, 32'h66, 5'd0, 32'h0, 5'd0, 32'h0,
                  3'b111, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    vecs[13] = mk(1'b0, 3'b001, 5'd7, 32'h77, 5'd0, 32'h0, 5'd0, 32'h0,
                  3'b111, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0000_0040);
    vecs[14] = idle(3'b111, 1'b1, 5'd6, 32'h66, 32'h0000_00C0);
    vecs[15] = idle(3'b111, 1'b1, 5'd7, 32'h77, 32'h0000_0080);
    vecs[16] = idle(3'b111, 1'b0, 5'd7, 32'h77, 32'h0);
    vecs[17] = mk(1'b0, 3'b111, 5'd8, 32'h08, 5'd9, 32'h09, 5'd10, 32'h0A,
                  3'b111, 1'b0, 5'd7, 32'h77, 32'h0);
    for (int i = 18; i <= 20; i++) begin
      vecs[i] = mk(1'b1, 3'b111, 5'd11, 32'hBAD, 5'd12, 32'hBAD, 5'd13, 32'hBAD,
                   3'b000, 1'b0, 5'd7, 32'h77, 32'h0000_0700);
    end
    vecs[21] = idle(3'b010, 1'b0, 5'd7, 32'h77, 32'h0000_0700);
    vecs[22] = idle(3'b110, 1'b1, 5'd9, 32'h09, 32'h0000_0700);
    vecs[23] = idle(3'b111, 1'b1, 5'd10, 32'h0A, 32'h0000_0500);
    vecs[24] = idle(3'b111, 1'b1, 5'd8, 32'h08, 32'h0000_0100);
    vecs[25] = idle(3'b111, 1'b0, 5'd8, 32'h08, 32'h0);

    drive(vecs[0]);
    step();
    check("reset_ready", 32'(wbif.src_ready_o), 32'h7);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ready", i), 32'(wbif.src_ready_o), 32'(vecs[i].ready));
      check($sformatf("v%0d_we", i),    32'(wbif.we_o),        32'(vecs[i].we));
      check($sformatf("v%0d_addr", i),  32'(wbif.w_iaddr_o),   32'(vecs[i].addr));
      check($sformatf("v%0d_wdata", i), wbif.wr_idata_o,       vecs[i].wdata);
      check($sformatf("v%0d_busy", i),  wbif.busy_mask_o,      vecs[i].busy);
      step();
    end

    // Mid-operation reset: two held results (pointer currently at MUL) must vanish.
    drive(mk(1'b0, 3'b011, 5'd1, 32'h101, 5'd2, 32'h202, 5'd0, 32'h0,
             3'b000, 1'b0, 5'd0, 32'h0, 32'h0));
    step();
    drive(vecs[0]);
    rst_n = 1'b0;
    #1;
    check("mr_held_busy", wbif.busy_mask_o, 32'h0000_0006);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("mr_we_%0d", c),    32'(wbif.we_o),        32'h0);
      check($sformatf("mr_busy_%0d", c),  wbif.busy_mask_o,      32'h0);
      check($sformatf("mr_ready_%0d", c), 32'(wbif.src_ready_o), 32'h7);
      if (c == 2) begin
        drive(mk(1'b0, 3'b011, 5'd3, 32'h303, 5'd4, 32'h404, 5'd0, 32'h0,
                 3'b000, 1'b0, 5'd0, 32'h0, 32'h0));
      end
      step();
    end
    drive(vecs[0]);

    // Pointer must be back at ALU: x3 is written before x4.
    begin
      int n;
      n = 0;
      while (!wbif.we_o && n < 4) begin
        step();
        n++;
      end
      check("mr_wait_bounded", 32'(n < 4), 32'h1);
      check("mr_first_addr", 32'(wbif.w_iaddr_o), 32'd3);
      check("mr_first_data", wbif.wr_idata_o, 32'h303);
      step();
      check("mr_second_we",   32'(wbif.we_o),      32'h1);
      check("mr_second_addr", 32'(wbif.w_iaddr_o), 32'd4);
      check("mr_second_data", wbif.wr_idata_o,     32'h404);
      step();
      check("mr_end_we",   32'(wbif.we_o),   32'h0);
      check("mr_end_busy", wbif.busy_mask_o, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mgt_01_i_writeback_arbiter.md
# mgt_01_i_writeback_arbiter

Integer writeback stage of MicroGT-01. Collects results from the ALU, multiplier and load/store unit, buffers one result per source, and arbitrates them round-robin onto the single integer register file write port. Exports a per-register pending-write mask that the issue stage uses for RAW hazard stalls. Sits directly upstream of the integer register file and drives its write enable, write address and write data.

## Interface
- `N_SRC`, 3, number of result sources; index 0 = ALU, 1 = MUL, 2 = LSU; fixed at 3 for this design.
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `stall_i`  in  1  global pipeline stall; freezes the block.
- `src_valid_i[N_SRC]`  in  1 each  source result valid.
- `src_rd_i[N_SRC]`  in  `i_register_e` each  destination register.
- `src_data_i[N_SRC]`  in  `data_bus_t` each  result value.
- `src_ready_o[N_SRC]`  out  1 each  holding register can accept this cycle.
- `we_o`  out  1  register file write enable (registered).
- `w_iaddr_o`  out  `i_register_e`  write address (registered).
- `wr_idata_o`  out  `data_bus_t`  write data (registered).
- `busy_mask_o`  out  32  bit r = write to xr pending inside this block.

## Operation
- Per source: one holding entry {valid, rd, data}. A handshake occurs when `src_valid_i & src_ready_o`.
- `src_ready_o[s]` = `!stall_i & (!hold_valid[s] | grant[s])`. This is combinational from state and grant, with no path from `src_valid_i` to `src_ready_o`.
- A handshake with `src_rd_i == X0` is consumed and discarded. The holding entry is not loaded.
- Arbitration: among valid holding entries, grant one per cycle, round-robin. Search starts at `rr_ptr`. After a grant to s, `rr_ptr` = (s+1) mod 3. With no grant, `rr_ptr` is unchanged.
- Granted entry is copied into the output register: `we_o`<=1, `w_iaddr_o`<=rd, `wr_idata_o`<=data. Its holding valid clears unless the same source handshakes in the same cycle; in that case the entry reloads with the new result.
- No grant this cycle: `we_o`<=0; `w_iaddr_o`/`wr_idata_o` hold their values.
- `stall_i`=1: no handshakes, no grant, `rr_ptr` and holding entries frozen, `we_o`<=0 next cycle.
- `busy_mask_o[r]` = OR over s of (`hold_valid[s]` & rd[s]==r), OR (`we_o` & `w_iaddr_o`==r). Bit 0 is always 0.
- Ordering: producers never have two in-flight results with the same rd. Issue stalls on `busy_mask_o` to guarantee this. This is a checked assertion, not handled in RTL.

## Timing
- Reset (`rst_n_i`=0 at a rising edge): all `hold_valid`=0, `rr_ptr`=0, `we_o`=0, `w_iaddr_o`=X0, `wr_idata_o`=0. During reset, `src_ready_o`=1 (entries empty) but handshakes are ignored. `busy_mask_o`=0 the cycle after reset.
- Reset mid-operation discards all held results; no write is issued.
- Latency: handshake in cycle N, then entry valid in N+1. If granted in N+1, `we_o`=1 in N+2 and the register file updates at the end of N+2. Minimum latency is 2 cycles.
- Throughput: one register file write per cycle. Each source can sustain one result per cycle only while it is granted every cycle.
- Worst-case wait for a valid entry: 2 grants to other sources. The entry is then written within 3 cycles of becoming valid, provided there is no stall.
- `busy_mask_o` bit for rd is set from N+1 through N+2 inclusive. It clears in the cycle after the register file write.

## Structure
- Shared package (Modules_pkg): `wb_entry_t` struct {valid, `i_register_e` rd, `data_bus_t` data}, plus source index constants `WB_SRC_ALU`=0, `WB_SRC_MUL`=1, `WB_SRC_LSU`=2. Reuse existing `i_register_e`, `data_bus_t`, `X0`, `XLEN`.
- Natural sub-module: `mgt_01_rr_arbiter_3`. Combinational grant from request vector and `rr_ptr`, one-hot output. Pointer register lives in the parent.

## Test plan
- Reset then idle: `we_o`=0, `busy_mask_o`=0, all `src_ready_o`=1, `w_iaddr_o`=X0.
- ALU only: rd=x5, data=0xDEADBEEF at cycle N. Expect `busy_mask_o[5]`=1 in N+1 and N+2, then `we_o`=1 with x5/0xDEADBEEF in N+2, then `busy_mask_o`=0 in N+3.
- All three valid simultaneously: ALU x1=0x11, MUL x2=0x22, LSU x3=0x33. Expect writes x1, x2, x3 in consecutive cycles. `src_ready_o` of the losers stays 0 until each is granted.
- Write to X0 from MUL: handshake accepted, no `we_o`, `busy_mask_o[0]` never set.
- `stall_i`=1 for 3 cycles with all entries full: `we_o`=0, all `src_ready_o`=0, entries and `rr_ptr` unchanged. After release, grant order resumes from the stored `rr_ptr`.
- `rst_n_i` low for one cycle while 2 entries are held: no subsequent `we_o`, `busy_mask_o`=0, and `rr_ptr` back to ALU.
